// File: rtl/sol1_bus_target_if.sv
// rtl/sol1_bus_target_if.sv - CPU external bus signals seen by a memory/IO target
interface sol1_bus_target_if;
    logic [21:0] addr;
    logic [7:0]  data_out;
    logic        rd;
    logic        wr;
    logic        mem_io;
    logic [7:0]  data_in;
    logic        data_oe;
    logic        WAIT;

    modport master (
        output addr, data_out, rd, wr, mem_io,
        input  data_in, data_oe, WAIT
    );

    modport slave (
        input  addr, data_out, rd, wr, mem_io,
        output data_in, data_oe, WAIT
    );
endinterface

// File: rtl/sol1_bus_target.sv
// rtl/sol1_bus_target.sv - wait-stated byte RAM responder on the CPU bus
// SOL1_TGT_DOORBELL_EN: last offset of the window becomes an interrupt doorbell.
module sol1_bus_target #(
    parameter logic [21:0] BASE        = 22'h000000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic        MEM_IO_SEL  = 1'b0
) (
    input  logic               clk,
    input  logic               arst,
    sol1_bus_target_if.slave   bus,
    output logic               prot_err,
    output logic               irq_out
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [22:0] LIMIT    = {1'b0, BASE} + 23'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t         state, state_d;
    logic [3:0]     cnt, cnt_d;
    logic           hit, strobe, accept, done_entry;
    logic [AW-1:0]  cur_off, off_q, off_d;
    logic           wr_q, wr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     mem [DEPTH];

    assign hit     = (bus.mem_io == MEM_IO_SEL) && (bus.addr >= BASE) && ({1'b0, bus.addr} < LIMIT);
    assign strobe  = bus.rd ^ bus.wr;
    assign cur_off = AW'(bus.addr - BASE);

    // A simultaneous rd/wr never stalls the CPU; it only raises prot_err.
    assign bus.WAIT = hit && strobe && (state != DONE) && !(bus.rd && bus.wr);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        accept     = 1'b0;
        done_entry = 1'b0;
        case (state)
            IDLE: begin
                if (hit && strobe) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = COUNT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = DONE;
                        done_entry = 1'b1;
                    end
                end
            end
            COUNT: begin
                if (!hit || !strobe) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_d    = DONE;
                    done_entry = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!strobe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states DONE is entered straight from IDLE, so use live bus values.
    always_comb begin
        off_d   = off_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        if (accept) begin
            off_d   = cur_off;
            wr_d    = bus.wr;
            wdata_d = bus.data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            off_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
        end else if (accept) begin
            off_q   <= off_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            bus.data_in <= 8'h00;
            bus.data_oe <= 1'b0;
        end else if (done_entry && !wr_d) begin
            bus.data_in <= mem[off_d];
            bus.data_oe <= 1'b1;
        end else if (state == DONE && !strobe) begin
            bus.data_in <= 8'h00;
            bus.data_oe <= 1'b0;
        end
    end

    // RAM contents survive reset; only the pending write is dropped.
    always_ff @(posedge clk) begin
        if (!arst && done_entry && wr_d) begin
            mem[off_d] <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            prot_err <= 1'b0;
        end else if (hit && bus.rd && bus.wr) begin
            prot_err <= 1'b1;
        end
    end

`ifdef SOL1_TGT_DOORBELL_EN
    localparam logic [AW-1:0] BELL_OFF = AW'(DEPTH - 1);

    logic irq_q;

    always_ff @(posedge clk) begin
        if (arst) begin
            irq_q <= 1'b0;
        end else if (done_entry && off_d == BELL_OFF) begin
            irq_q <= wr_d;
        end
    end

    assign irq_out = irq_q;
`else
    assign irq_out = 1'b0;
`endif
endmodule
